// File: rtl/morse_decoder.sv
// Purpose: rebuilds 12-bit Morse letter frames from a strobed serial line, decodes letters A..H.
// Latency: ValidOut/ErrorOut pulse in the cycle after the edge that samples the last bit or expires the timeout.
// Backpressure: none; every strobe is consumed except one landing in the single DONE cycle, which is dropped.
// Ports: ClockIn/Reset (sync, active-high); DotDashIn + NewBitIn serial input;
//        LetterOut (last good letter), ValidOut/ErrorOut (one-cycle frame result), Busy (frame in progress).
module morse_decoder #(
    parameter int CLOCK_FREQUENCY = 500,
    parameter int BITS_PER_LETTER = 12,
    parameter int TIMEOUT_CYCLES  = CLOCK_FREQUENCY
) (
    input  logic       ClockIn,
    input  logic       Reset,
    input  logic       DotDashIn,
    input  logic       NewBitIn,
    output logic [2:0] LetterOut,
    output logic       ValidOut,
    output logic       ErrorOut,
    output logic       Busy
);

    localparam int BCW = $clog2(BITS_PER_LETTER + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(BITS_PER_LETTER - 1);
    localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [TCW-1:0] TMO_MAX  = TCW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

    state_t         r_state;
    logic [BCW-1:0] r_bitcnt;
    logic [TCW-1:0] r_tmo;
    logic [2:0]     r_run;     // current mark run length, saturates at 4
    logic [1:0]     r_space;   // current space length, saturates at 2
    logic           r_end;     // a space of two or more zeros has been seen
    logic           r_bad;     // sticky malformed flag for this frame
    logic [3:0]     r_code;    // dash=1 / dot=0, first symbol ends up in the MSB of the used field
    logic [2:0]     r_cnt;

    logic           w_last;
    logic           w_close;
    logic [2:0]     w_close_run;
    logic [2:0]     w_run;
    logic [1:0]     w_space;
    logic           w_end;
    logic           w_bad;
    logic [3:0]     w_code;
    logic [2:0]     w_cnt;
    logic           w_ok;
    logic [2:0]     w_letter;

    // Frame state as it would be after absorbing the current sample, plus the
    // decode of that state, which is only used when the sample ends the frame.
    always_comb begin
        w_run       = r_run;
        w_space     = r_space;
        w_end       = r_end;
        w_bad       = r_bad;
        w_code      = r_code;
        w_cnt       = r_cnt;
        w_close     = 1'b0;
        w_close_run = r_run;
        w_last      = (r_bitcnt == LAST_BIT);

        if (DotDashIn) begin
            if (r_end) begin
                w_bad = 1'b1;
            end
            if (r_run != 3'd4) begin
                w_run = r_run + 3'd1;
            end
            w_space     = 2'd0;
            // A mark still open on the last bit is closed by the frame end.
            w_close     = w_last;
            w_close_run = w_run;
        end else begin
            w_close     = (r_run != 3'd0);
            w_close_run = r_run;
            w_run       = 3'd0;
            if (r_space != 2'd2) begin
                w_space = r_space + 2'd1;
            end
            if (r_space != 2'd0) begin
                w_end = 1'b1;
            end
        end

        if (w_close) begin
            if (w_close_run != 3'd1 && w_close_run != 3'd3) begin
                w_bad = 1'b1;
            end else if (r_cnt == 3'd4) begin
                w_bad = 1'b1;
            end else begin
                w_code = {r_code[2:0], (w_close_run == 3'd3)};
                w_cnt  = r_cnt + 3'd1;
            end
        end

        w_ok     = ~w_bad;
        w_letter = 3'd0;
        case ({w_cnt, w_code})
            {3'd2, 4'b0001}: w_letter = 3'd0;  // A .-
            {3'd4, 4'b1000}: w_letter = 3'd1;  // B -...
            {3'd4, 4'b1010}: w_letter = 3'd2;  // C -.-.
            {3'd3, 4'b0100}: w_letter = 3'd3;  // D -..
            {3'd1, 4'b0000}: w_letter = 3'd4;  // E .
            {3'd4, 4'b0010}: w_letter = 3'd5;  // F ..-.
            {3'd3, 4'b0110}: w_letter = 3'd6;  // G --.
            {3'd4, 4'b0000}: w_letter = 3'd7;  // H ....
            default:         w_ok     = 1'b0;
        endcase
    end

    always_ff @(posedge ClockIn) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_bitcnt  <= '0;
            r_tmo     <= '0;
            r_run     <= 3'd0;
            r_space   <= 2'd0;
            r_end     <= 1'b0;
            r_bad     <= 1'b0;
            r_code    <= 4'd0;
            r_cnt     <= 3'd0;
            LetterOut <= 3'd0;
            ValidOut  <= 1'b0;
            ErrorOut  <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            ValidOut <= 1'b0;
            ErrorOut <= 1'b0;
            case (r_state)
                IDLE, RECV: begin
                    if (NewBitIn) begin
                        r_bitcnt <= r_bitcnt + 1'b1;
                        r_tmo    <= '0;
                        r_run    <= w_run;
                        r_space  <= w_space;
                        r_end    <= w_end;
                        r_bad    <= w_bad;
                        r_code   <= w_code;
                        r_cnt    <= w_cnt;
                        if (w_last) begin
                            r_state <= DONE;
                            Busy    <= 1'b0;
                            if (w_ok) begin
                                ValidOut  <= 1'b1;
                                LetterOut <= w_letter;
                            end else begin
                                ErrorOut <= 1'b1;
                            end
                        end else begin
                            r_state <= RECV;
                            Busy    <= 1'b1;
                        end
                    end else if (r_state == RECV) begin
                        if (r_tmo != TMO_MAX) begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                        if (r_tmo == TMO_LAST) begin
                            r_state  <= DONE;
                            Busy     <= 1'b0;
                            ErrorOut <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Frame storage is wiped here so IDLE always starts clean.
                    r_state  <= IDLE;
                    r_bitcnt <= '0;
                    r_tmo    <= '0;
                    r_run    <= 3'd0;
                    r_space  <= 2'd0;
                    r_end    <= 1'b0;
                    r_bad    <= 1'b0;
                    r_code   <= 4'd0;
                    r_cnt    <= 3'd0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
// Purpose: randomized frame stimulus for morse_decoder checked against a string-level Morse model.
// Latency: result checked in the cycle after the 12th strobe; timeout error after 8 idle cycles.
// Backpressure: not applicable; strobes are spaced so that only deliberate gaps reach the timeout.
module tb_morse_decoder;

    logic       clk = 1'b0;
    logic       Reset;
    logic       DotDashIn;
    logic       NewBitIn;
    logic [2:0] LetterOut;
    logic       ValidOut;
    logic       ErrorOut;
    logic       Busy;

    int checks = 0;
    int errors = 0;
    logic [2:0] exp_letter = 3'd0;

    always #5 clk = ~clk;

    morse_decoder #(
        .CLOCK_FREQUENCY(500),
        .BITS_PER_LETTER(12),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .ClockIn  (clk),
        .Reset    (Reset),
        .DotDashIn(DotDashIn),
        .NewBitIn (NewBitIn),
        .LetterOut(LetterOut),
        .ValidOut (ValidOut),
        .ErrorOut (ErrorOut),
        .Busy     (Busy)
    );

    // Canonical frames for A..H.
    logic [11:0] letter_frames [8] = '{
        12'b101110000000, 12'b111010101000, 12'b111010111010, 12'b111010100000,
        12'b100000000000, 12'b101011101000, 12'b111011101000, 12'b101010100000
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: read the frame as text. Returns {ok, letter}.
    function automatic logic [3:0] ref_decode(input logic [11:0] f);
        string tbl [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};
        string sym = "";
        int    run = 0;
        int    zeros = 0;
        bit    ended = 0;
        bit    bad = 0;
        logic  b;
        // Position -1 is a virtual trailing zero that closes a mark open at frame end.
        for (int i = 11; i >= -1; i--) begin
            b = (i >= 0) ? f[i] : 1'b0;
            if (b) begin
                if (ended) bad = 1;
                run++;
                zeros = 0;
            end else begin
                if (run == 1)      sym = {sym, "."};
                else if (run == 3) sym = {sym, "-"};
                else if (run != 0) bad = 1;
                run = 0;
                zeros++;
                if (zeros >= 2) ended = 1;
            end
        end
        if (sym.len() > 4) bad = 1;
        if (!bad) begin
            for (int k = 0; k < 8; k++) begin
                if (sym == tbl[k]) return {1'b1, 3'(k)};
            end
        end
        return 4'b0000;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            DotDashIn = 1'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic b);
        DotDashIn = b;
        NewBitIn  = 1'b1;
        @(posedge clk);
        #1;
        NewBitIn  = 1'b0;
        DotDashIn = 1'($urandom);
    endtask

    // Sends a whole frame and returns in the DONE cycle after checking the result.
    task automatic send_frame(input string tag, input logic [11:0] f, input int gap);
        logic [3:0] r;
        r = ref_decode(f);
        for (int i = 11; i >= 0; i--) begin
            strobe(f[i]);
            if (i > 0) begin
                check({tag, "_busy_mid"}, Busy, 1);
                check({tag, "_pulse_mid"}, {ValidOut, ErrorOut}, 0);
                idle(gap - 1);
            end
        end
        if (r[3]) exp_letter = r[2:0];
        check({tag, "_valid"}, ValidOut, r[3]);
        check({tag, "_error"}, ErrorOut, !r[3]);
        check({tag, "_letter"}, LetterOut, exp_letter);
        check({tag, "_busy_done"}, Busy, 0);
    endtask

    task automatic after_done(input string tag);
        idle(1);
        check({tag, "_pulse_end"}, {ValidOut, ErrorOut}, 0);
        check({tag, "_busy_end"}, Busy, 0);
    endtask

    initial begin
        int          seen;
        int          early;
        logic [11:0] f;

        Reset     = 1'b1;
        NewBitIn  = 1'b0;
        DotDashIn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_letter", LetterOut, 0);
        check("rst_valid", ValidOut, 0);
        check("rst_error", ErrorOut, 0);
        check("rst_busy", Busy, 0);
        Reset = 1'b0;
        idle(2);

        send_frame("A", 12'b101110000000, 5);
        after_done("A");
        idle(3);
        send_frame("C", 12'b111010111010, 5);
        after_done("C");
        send_frame("E", 12'b100000000000, 5);
        after_done("E");
        send_frame("run2", 12'b110000000000, 3);
        after_done("run2");
        send_frame("dashdash", 12'b111011100000, 2);
        after_done("dashdash");

        // Five bits of H, then silence until the timeout fires.
        for (int i = 0; i < 5; i++) begin
            strobe(i[0] ? 1'b0 : 1'b1);
            if (i < 4) idle(4);
        end
        early = 0;
        for (int k = 0; k < 8; k++) begin
            if (ErrorOut || !Busy) early++;
            idle(1);
        end
        check("tmo_early", early, 0);
        check("tmo_error", ErrorOut, 1);
        check("tmo_valid", ValidOut, 0);
        check("tmo_busy", Busy, 0);
        check("tmo_letter", LetterOut, exp_letter);
        after_done("tmo");
        send_frame("H", 12'b101010100000, 4);
        after_done("H");

        // Abort B after six bits with a reset.
        for (int i = 11; i >= 6; i--) begin
            strobe(letter_frames[1][i]);
            idle(2);
        end
        Reset = 1'b1;
        @(posedge clk);
        #1;
        Reset = 1'b0;
        exp_letter = 3'd0;
        check("abort_letter", LetterOut, 0);
        check("abort_busy", Busy, 0);
        seen = 0;
        repeat (20) begin
            if (ErrorOut || ValidOut) seen++;
            idle(1);
        end
        check("abort_no_pulse", seen, 0);
        send_frame("B", letter_frames[1], 3);
        after_done("B");

        // Strobe landing in DONE must be dropped.
        send_frame("D", letter_frames[3], 2);
        strobe(1'b1);
        check("drop_busy", Busy, 0);
        idle(2);
        send_frame("G", letter_frames[6], 3);
        after_done("G");

        repeat (150) begin
            case ($urandom_range(0, 3))
                0: f = 12'($urandom);
                1: begin
                    f = letter_frames[$urandom_range(0, 7)];
                    f[$urandom_range(0, 11)] ^= 1'b1;
                end
                default: f = letter_frames[$urandom_range(0, 7)];
            endcase
            send_frame("rnd", f, $urandom_range(1, 8));
            after_done("rnd");
            idle($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
